// File: rtl/gray_stream_decoder_pkg.sv
// Shared state encodings and defaults for the Gray-code stream decoder.
package gray_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_LOCKED = 2'd1,
    ST_FAULT  = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_ERR_W = 8;

endpackage

// File: rtl/gray_stream_decoder_if.sv
// Sample stream into the decoder plus its decoded result and tracking flags.
interface gray_stream_decoder_if #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] gray_in;
  logic             out_valid;
  logic [WIDTH-1:0] bin_out;
  logic             dir_up;
  logic             repeat_o;
  logic             step_err;
  logic             locked;
  logic [ERR_W-1:0] err_count;

  modport master (
    output in_valid, gray_in,
    input  out_valid, bin_out, dir_up, repeat_o, step_err, locked, err_count
  );

  modport slave (
    input  in_valid, gray_in,
    output out_valid, bin_out, dir_up, repeat_o, step_err, locked, err_count
  );
endinterface

// File: rtl/gray_stream_decoder_gray_to_bin.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR of all
// Gray bits at or above it, so no ripple chain through the output vector.
module gray_to_bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign o_bin[i] = ^i_gray[WIDTH-1:i];
  end

endmodule

// File: rtl/gray_stream_decoder.sv
// Two-stage Gray stream decoder: S1 captures the sample, S2 decodes it,
// classifies the step against the previous sample and tracks lock/fault state.
module gray_stream_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
) (
  input logic                  clk,
  input logic                  reset,
  gray_stream_decoder_if.slave bus
);

  localparam logic [WIDTH-1:0] STEP_UP   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] STEP_DOWN = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] STEP_NONE = {WIDTH{1'b0}};
  localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE   = {{(ERR_W-1){1'b0}}, 1'b1};

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_gray;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_prev;
  logic             r_dir_up;
  logic             r_repeat;
  logic             r_step_err;
  logic             r_locked;
  logic [ERR_W-1:0] r_err_count;
  state_e           r_state;

  logic [WIDTH-1:0] w_bin;
  logic [WIDTH-1:0] w_delta;
  state_e           w_state_next;
  logic             w_dir_next;
  logic             w_repeat;
  logic             w_step_err;
  logic             w_err_inc;

  gray_to_bin #(.WIDTH(WIDTH)) u_gray_to_bin (
    .i_gray (r_s1_gray),
    .o_bin  (w_bin)
  );

  // Modular difference makes the all-ones/all-zeros wrap an ordinary +/-1 step.
  assign w_delta = w_bin - r_prev;

  // Tracker next-state and per-sample flag decode.
  always_comb begin
    w_state_next = r_state;
    w_dir_next   = r_dir_up;
    w_repeat     = 1'b0;
    w_step_err   = 1'b0;
    w_err_inc    = 1'b0;
    if (r_s1_valid) begin
      case (r_state)
        ST_EMPTY: begin
          w_state_next = ST_LOCKED;
        end
        ST_LOCKED, ST_FAULT: begin
          if (w_delta == STEP_UP) begin
            w_dir_next   = 1'b1;
            w_state_next = ST_LOCKED;
          end else if (w_delta == STEP_DOWN) begin
            w_dir_next   = 1'b0;
            w_state_next = ST_LOCKED;
          end else if (w_delta == STEP_NONE) begin
            w_repeat = 1'b1;
          end else begin
            w_step_err   = 1'b1;
            w_err_inc    = (r_state == ST_LOCKED);
            w_state_next = ST_FAULT;
          end
        end
        default: begin
          w_state_next = ST_EMPTY;
        end
      endcase
    end else begin
      w_state_next = r_state;
    end
  end

  // Pipeline, tracker state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_gray   <= {WIDTH{1'b0}};
      r_out_valid <= 1'b0;
      r_bin       <= {WIDTH{1'b0}};
      r_prev      <= {WIDTH{1'b0}};
      r_dir_up    <= 1'b0;
      r_repeat    <= 1'b0;
      r_step_err  <= 1'b0;
      r_locked    <= 1'b0;
      r_err_count <= {ERR_W{1'b0}};
      r_state     <= ST_EMPTY;
    end else begin
      r_s1_valid  <= bus.in_valid;
      r_s1_gray   <= bus.gray_in;
      r_out_valid <= r_s1_valid;
      r_repeat    <= w_repeat;
      r_step_err  <= w_step_err;
      r_state     <= w_state_next;
      r_locked    <= (w_state_next == ST_LOCKED);
      r_dir_up    <= w_dir_next;
      if (r_s1_valid) begin
        r_bin  <= w_bin;
        r_prev <= w_bin;
      end
      if (w_err_inc && (r_err_count != ERR_MAX)) begin
        r_err_count <= r_err_count + ERR_ONE;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.bin_out   = r_bin;
  assign bus.dir_up    = r_dir_up;
  assign bus.repeat_o  = r_repeat;
  assign bus.step_err  = r_step_err;
  assign bus.locked    = r_locked;
  assign bus.err_count = r_err_count;

endmodule
